dpram_arbiter: RTL and testbench
================================

Name: dpram_arbiter

Overview:
- Shares one dual_port_ram instance (1024 x 8, two ports, common clock, registered read) among NUM_REQ requesters.
- Grants up to two requests per cycle, one per RAM port, using round-robin priority.
- Resolves same-address hazards between the two ports.
- Optionally zero-fills the RAM after reset before accepting traffic.
- Sits between fabric-mapped user logic and the dpram hard block.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- ADDR_W, 10, RAM address width; must equal the dpram depth log2.
- DATA_W, 8, RAM data width.
- CLEAR_ON_RESET, 1, when 1 the RAM is zero-filled after reset release; when 0 the block starts directly in RUN.

Ports:
- clk  in  1  single clock for the arbiter and the RAM
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_we  in  NUM_REQ  1 = write, 0 = read
- req_addr  in  NUM_REQ*ADDR_W  flattened addresses; requester i occupies slice i
- req_wdata  in  NUM_REQ*DATA_W  flattened write data
- req_ready  out  NUM_REQ  grant; the transfer occurs in a cycle where valid and ready are both 1
- rsp_valid  out  NUM_REQ  read data valid for requester i
- rsp_rdata  out  NUM_REQ*DATA_W  flattened read data
- busy_init  out  1  high while the zero-fill is in progress
- ram_wen1, ram_wen2  out  1  RAM write enables
- ram_addr1, ram_addr2  out  ADDR_W  RAM addresses, MSB-first [0:ADDR_W-1] to match the dpram port
- ram_din1, ram_din2  out  DATA_W  RAM write data
- ram_dout1, ram_dout2  in  DATA_W  RAM registered read data

Behaviour:
- Reset values (asynchronous, on rst_n low):
  - FSM = INIT if CLEAR_ON_RESET else RUN
  - clear counter = 0; rr_ptr = 0
  - req_ready = 0, rsp_valid = 0, rsp_rdata = 0
  - ram_wen1/2 = 0, ram_addr1/2 = 0, ram_din1/2 = 0
  - busy_init = CLEAR_ON_RESET
- FSM states: INIT, RUN.
  - INIT, each cycle: port1 writes 0 at address 2k, port2 writes 0 at address 2k+1; k increments.
  - INIT lasts 512 cycles for ADDR_W=10, i.e. 2^(ADDR_W-1) cycles.
  - After the cycle that writes 1022/1023, the FSM goes to RUN and busy_init drops in the same transition.
  - req_ready = 0 throughout INIT.
  - An rst_n assertion during INIT restarts the clear from k = 0.
- RUN arbitration is combinational from registered rr_ptr:
  - Scan requesters rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - The first valid requester is granted port1; the next valid requester is granted port2.
  - req_ready is combinational for the granted requesters.
- Hazard rule:
  - If both candidates target the same address and at least one is a write, only the port1 candidate is granted.
  - The port2 candidate is held and retries next cycle.
  - Two reads to the same address are both granted.
- rr_ptr update, at each clock edge with at least one grant: rr_ptr becomes (index of last granted requester) + 1, mod NUM_REQ. With no grants, rr_ptr holds.
- Port driving:
  - A granted write drives wen=1, addr, din.
  - A granted read drives wen=0 and addr.
  - An idle port drives wen=0 with the address held from the previous cycle, giving no spurious writes.
- Read latency:
  - A read granted at edge t registers its requester id into a per-port tag pipeline stage.
  - rsp_valid[id] = 1 and rsp_rdata slice = ram_doutN in cycle t+1 only, i.e. a one-cycle pulse.
  - No response backpressure: requesters must sink data.
  - Writes produce no response.
- A requester may be granted on both ports in one cycle only if it issues one request per cycle; it cannot, so max 1 grant per requester per cycle.
- Requests must remain stable while valid and not ready.
- Mid-operation reset: in-flight read tags are cleared and the pending rsp_valid is dropped.

Decomposition:
- Package dpram_arb_pkg:
  - ADDR_W/DATA_W defaults
  - FSM state enum {INIT, RUN}
  - clear-count width constant
  - helper function for the rotating priority pick
- Sub-module rr_pick2: combinational round-robin selector returning two one-hot grants plus a first-grant-index, reused for both ports.

Test Plan:
- Reset release with CLEAR_ON_RESET=1:
  - busy_init high for exactly 512 cycles.
  - Reads of addresses 0, 511, 1023 afterwards return 0x00.
  - req_ready = 0 during INIT.
- All 4 requesters continuously valid with reads:
  - Grants over 4 cycles are (0,1), (2,3), (0,1), (2,3).
  - Each rsp_valid arrives exactly one cycle after its grant.
- Req0 writes 0x5A @ 0x123, req1 reads 0x123 in the same cycle:
  - Req0 granted first, req1 granted next cycle.
  - Req1 receives 0x5A.
- Req2 and req3 both read 0x3FF, previously written 0xC3:
  - Both granted in the same cycle.
  - Both rsp_rdata = 0xC3 one cycle later.
- rst_n pulsed low at INIT cycle 200: the clear restarts and busy_init stays high for a further 512 cycles.
- Single requester alternating write/read over 0x000..0x00F: all read data match, and port2 is never used (ram_wen2 stays 0).

Source files
------------

// File: rtl/dpram_arb_pkg.sv
// dpram_arb_pkg: shared widths, FSM states and the rotating-priority helper for dpram_arbiter
package dpram_arb_pkg;
  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 8;
  localparam int MAX_REQ = 8;
  localparam int IDX_W = 3;
  typedef enum logic {INIT, RUN} state_t;
  function automatic int clr_width(input int addr_w);
    return addr_w - 1;
  endfunction
  // returns {found, index} of the first set bit scanning ptr, ptr+1, ... modulo n
  function automatic logic [IDX_W:0] rr_first(input logic [MAX_REQ-1:0] v, input logic [IDX_W-1:0] ptr, input int n);
    logic [IDX_W:0] r;
    int j;
    r = '0;
    for (int i = MAX_REQ - 1; i >= 0; i--)
      if (i < n) begin
        j = (int'(ptr) + i) % n;
        if (v[j]) r = {1'b1, IDX_W'(j)};
      end
    return r;
  endfunction
endpackage

// File: rtl/dpram_arbiter_rr_pick2.sv
// rr_pick2: combinational round-robin selector picking the first two valid requesters from ptr
module rr_pick2 import dpram_arb_pkg::*; #(
  parameter int N = 4
) (
  input  logic [N-1:0]     valid,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt1,
  output logic [N-1:0]     gnt2,
  output logic             hit1,
  output logic             hit2,
  output logic [IDX_W-1:0] idx1,
  output logic [IDX_W-1:0] idx2
);
  logic [MAX_REQ-1:0] v_ext, v_rest;
  logic [IDX_W:0] p1, p2;
  always_comb begin
    v_ext = MAX_REQ'(valid);
    p1 = rr_first(v_ext, ptr, N);
    v_rest = v_ext & ~(MAX_REQ'(p1[IDX_W]) << p1[IDX_W-1:0]);
    p2 = rr_first(v_rest, ptr, N);
    hit1 = p1[IDX_W];
    hit2 = p2[IDX_W];
    idx1 = p1[IDX_W-1:0];
    idx2 = p2[IDX_W-1:0];
    gnt1 = hit1 ? N'(1) << idx1 : '0;
    gnt2 = hit2 ? N'(1) << idx2 : '0;
  end
endmodule

// File: rtl/dpram_arbiter.sv
// dpram_arbiter: shares one dual-port RAM among NUM_REQ requesters, two round-robin grants per cycle,
// with same-address hazard suppression and optional zero-fill after reset.
module dpram_arbiter import dpram_arb_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [NUM_REQ*DATA_W-1:0] rsp_rdata,
  output logic                      busy_init,
  output logic                      ram_wen1,
  output logic                      ram_wen2,
  output logic [0:ADDR_W-1]         ram_addr1,
  output logic [0:ADDR_W-1]         ram_addr2,
  output logic [DATA_W-1:0]         ram_din1,
  output logic [DATA_W-1:0]         ram_din2,
  input  logic [DATA_W-1:0]         ram_dout1,
  input  logic [DATA_W-1:0]         ram_dout2
);
  localparam int CLR_W = clr_width(ADDR_W);
  state_t state, state_nx;
  logic [CLR_W-1:0] clr_cnt;
  logic [IDX_W-1:0] rr_ptr, idx1, idx2, tag_id1, tag_id2;
  logic [NUM_REQ-1:0] gnt1, gnt2_raw;
  logic hit1, hit2_raw, hit2, hazard, run, we1, we2, tag_v1, tag_v2;
  logic [ADDR_W-1:0] a1, a2, addr_q1, addr_q2;
  logic [DATA_W-1:0] d1, d2;

  rr_pick2 #(.N(NUM_REQ)) u_pick (
    .valid(req_valid), .ptr(rr_ptr), .gnt1(gnt1), .gnt2(gnt2_raw),
    .hit1(hit1), .hit2(hit2_raw), .idx1(idx1), .idx2(idx2)
  );

  assign run = rst_n && state == RUN;
  assign busy_init = state == INIT;

  always_comb begin
    a1 = req_addr[int'(idx1)*ADDR_W +: ADDR_W];
    a2 = req_addr[int'(idx2)*ADDR_W +: ADDR_W];
    d1 = req_wdata[int'(idx1)*DATA_W +: DATA_W];
    d2 = req_wdata[int'(idx2)*DATA_W +: DATA_W];
    we1 = req_we[idx1];
    we2 = req_we[idx2];
    hazard = hit1 && hit2_raw && a1 == a2 && (we1 || we2);
    hit2 = hit2_raw && !hazard;
    state_nx = state;
    req_ready = '0;
    ram_wen1 = 1'b0;
    ram_wen2 = 1'b0;
    ram_addr1 = addr_q1;
    ram_addr2 = addr_q2;
    ram_din1 = '0;
    ram_din2 = '0;
    // writes are gated by rst_n so nothing reaches the RAM while reset is held
    if (rst_n && state == INIT) begin
      ram_wen1 = 1'b1;
      ram_wen2 = 1'b1;
      ram_addr1 = {clr_cnt, 1'b0};
      ram_addr2 = {clr_cnt, 1'b1};
      state_nx = &clr_cnt ? RUN : INIT;
    end else if (run) begin
      req_ready = gnt1 | (hit2 ? gnt2_raw : '0);
      ram_wen1 = hit1 && we1;
      ram_wen2 = hit2 && we2;
      ram_addr1 = hit1 ? a1 : addr_q1;
      ram_addr2 = hit2 ? a2 : addr_q2;
      ram_din1 = hit1 ? d1 : '0;
      ram_din2 = hit2 ? d2 : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= CLEAR_ON_RESET ? INIT : RUN;
      clr_cnt <= '0;
      rr_ptr <= '0;
      addr_q1 <= '0;
      addr_q2 <= '0;
      tag_v1 <= 1'b0;
      tag_v2 <= 1'b0;
      tag_id1 <= '0;
      tag_id2 <= '0;
    end else begin
      state <= state_nx;
      clr_cnt <= state == INIT ? clr_cnt + 1'b1 : clr_cnt;
      addr_q1 <= ram_addr1;
      addr_q2 <= ram_addr2;
      tag_v1 <= run && hit1 && !we1;
      tag_v2 <= run && hit2 && !we2;
      tag_id1 <= idx1;
      tag_id2 <= idx2;
      if (run && hit1) rr_ptr <= IDX_W'((int'(hit2 ? idx2 : idx1) + 1) % NUM_REQ);
    end

  always_comb begin
    rsp_valid = '0;
    rsp_rdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (tag_v1 && tag_id1 == IDX_W'(i)) begin
        rsp_valid[i] = 1'b1;
        rsp_rdata[i*DATA_W +: DATA_W] = ram_dout1;
      end
      if (tag_v2 && tag_id2 == IDX_W'(i)) begin
        rsp_valid[i] = 1'b1;
        rsp_rdata[i*DATA_W +: DATA_W] = ram_dout2;
      end
    end
  end
endmodule

// File: tb/tb_dpram_arbiter.sv
// tb_dpram_arbiter: directed and randomized checks of dpram_arbiter against a request-level model
module tb_dpram_arbiter;
  localparam int NR = 4;
  logic clk = 1'b0;
  logic rst_n;
  logic [NR-1:0] req_valid, req_we, req_ready, rsp_valid;
  logic [NR*10-1:0] req_addr;
  logic [NR*8-1:0] req_wdata, rsp_rdata;
  logic busy_init, ram_wen1, ram_wen2;
  logic [0:9] ram_addr1, ram_addr2;
  logic [7:0] ram_din1, ram_din2, ram_dout1, ram_dout2;

  logic [NR-1:0] v, we;
  logic [9:0] ad [NR];
  logic [7:0] wd [NR];
  logic [7:0] mem [0:1023];
  logic [7:0] ref_mem [0:1023];
  int n_chk = 0, n_err = 0, mptr = 0;
  logic [NR-1:0] exp_rv, last_g;
  logic [31:0] exp_rd;
  logic wen2_or, ready_or;

  always #5 clk = ~clk;

  assign req_valid = v;
  assign req_we = we;
  assign req_addr = {ad[3], ad[2], ad[1], ad[0]};
  assign req_wdata = {wd[3], wd[2], wd[1], wd[0]};

  dpram_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .busy_init(busy_init), .ram_wen1(ram_wen1), .ram_wen2(ram_wen2), .ram_addr1(ram_addr1),
    .ram_addr2(ram_addr2), .ram_din1(ram_din1), .ram_din2(ram_din2), .ram_dout1(ram_dout1),
    .ram_dout2(ram_dout2)
  );

  // RAM stand-in: registered read; filled with non-zero junk while reset is held
  always @(posedge clk) begin
    if (!rst_n)
      for (int i = 0; i < 1024; i++) mem[i] <= 8'(i) | 8'h80;
    else begin
      if (ram_wen1) mem[ram_addr1] <= ram_din1;
      if (ram_wen2) mem[ram_addr2] <= ram_din2;
    end
    ram_dout1 <= mem[ram_addr1];
    ram_dout2 <= mem[ram_addr2];
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // request-level model: rotate from mptr, take the first two valid, drop the second on an address clash involving a write
  task automatic model_eval();
    int first, second, r;
    logic [NR-1:0] g;
    first = -1;
    second = -1;
    for (int k = 0; k < NR; k++) begin
      r = (mptr + k) % NR;
      if (v[r]) begin
        if (first < 0) first = r;
        else if (second < 0) second = r;
      end
    end
    if (second >= 0 && ad[first] == ad[second] && (we[first] || we[second])) second = -1;
    g = '0;
    if (first >= 0) g[first] = 1'b1;
    if (second >= 0) g[second] = 1'b1;
    chk("ready", 32'(req_ready), 32'(g));
    chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
    chk("rsp_rdata", rsp_rdata, exp_rd);
    wen2_or |= ram_wen2;
    exp_rv = '0;
    exp_rd = '0;
    for (int i = 0; i < NR; i++)
      if (g[i] && !we[i]) begin
        exp_rv[i] = 1'b1;
        exp_rd[i*8 +: 8] = ref_mem[ad[i]];
      end
    for (int i = 0; i < NR; i++)
      if (g[i] && we[i]) ref_mem[ad[i]] = wd[i];
    if (first >= 0) mptr = ((second >= 0 ? second : first) + 1) % NR;
    last_g = g;
  endtask

  task automatic cycle();
    @(negedge clk);
    model_eval();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic vv, input logic w, input logic [9:0] a, input logic [7:0] d);
    v[i] = vv;
    we[i] = w;
    ad[i] = a;
    wd[i] = d;
  endtask

  initial begin
    int n;
    logic [7:0] val;
    rst_n = 1'b1;
    v = '1;
    we = '0;
    for (int i = 0; i < NR; i++) begin
      ad[i] = 10'(i);
      wd[i] = 8'h00;
    end
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy_init), 32'd1);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_rspv", 32'(rsp_valid), 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_wen", {ram_wen1, ram_wen2}, 32'd0);
    chk("rst_addr", {ram_addr1, ram_addr2}, 32'd0);
    rst_n = 1'b1;
    ready_or = 1'b0;
    // zero-fill interrupted by a reset at cycle 200, then allowed to finish
    repeat (200) begin
      @(posedge clk);
      #1;
      ready_or |= |req_ready;
    end
    chk("busy_mid", 32'(busy_init), 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    n = 0;
    while (busy_init && n < 2000) begin
      ready_or |= |req_ready;
      @(posedge clk);
      #1;
      n++;
    end
    v = '0;
    chk("init_len", n, 32'd512);
    chk("ready_init", 32'(ready_or), 32'd0);
    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
    mptr = 0;
    exp_rv = '0;
    exp_rd = '0;
    wen2_or = 1'b0;
    // four continuous readers: pairs (0,1),(2,3),(0,1),(2,3)
    set_req(0, 1, 0, 10'd0, 0);
    set_req(1, 1, 0, 10'd511, 0);
    set_req(2, 1, 0, 10'd1023, 0);
    set_req(3, 1, 0, 10'd5, 0);
    for (int c = 0; c < 4; c++) begin
      cycle();
      chk("rr_pair", 32'(last_g), (c % 2) == 0 ? 32'h3 : 32'hC);
      if (c == 0) chk("clr_rd01", {rsp_valid[1:0], rsp_rdata[15:0]}, {14'd0, 2'b11, 16'h0000});
      if (c == 1) chk("clr_rd23", {rsp_valid[3:2], rsp_rdata[31:16]}, {14'd0, 2'b11, 16'h0000});
    end
    v = '0;
    cycle();
    // write/read clash on 0x123: read deferred one cycle and sees the new byte
    set_req(0, 1, 1, 10'h123, 8'h5A);
    set_req(1, 1, 0, 10'h123, 8'h00);
    cycle();
    chk("haz_first", 32'(last_g), 32'h1);
    v[0] = 1'b0;
    cycle();
    chk("haz_second", 32'(last_g), 32'h2);
    v = '0;
    chk("haz_rdata", {rsp_valid[1], rsp_rdata[15:8]}, {23'd0, 1'b1, 8'h5A});
    cycle();
    // two reads of the same address are granted together
    set_req(2, 1, 1, 10'h3FF, 8'hC3);
    cycle();
    chk("wr_3ff", 32'(last_g), 32'h4);
    set_req(2, 1, 0, 10'h3FF, 8'h00);
    set_req(3, 1, 0, 10'h3FF, 8'h00);
    cycle();
    chk("rr_same", 32'(last_g), 32'hC);
    v = '0;
    chk("rr_same_data", {rsp_valid[3:2], rsp_rdata[31:16]}, {14'd0, 2'b11, 16'hC3C3});
    cycle();
    // a lone requester never needs port 2
    wen2_or = 1'b0;
    for (int a = 0; a < 16; a++) begin
      val = 8'(a) ^ 8'hA5;
      set_req(1, 1, 1, 10'(a), val);
      cycle();
      set_req(1, 1, 0, 10'(a), 8'h00);
      cycle();
      chk("solo_rd", {rsp_valid[1], rsp_rdata[15:8]}, {23'd0, 1'b1, val});
    end
    v = '0;
    cycle();
    chk("port2_idle", 32'(wen2_or), 32'd0);
    // randomized traffic on a small address pool to provoke clashes
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NR; i++)
        if (last_g[i] || !v[i])
          set_req(i, ($urandom % 4) != 0, 1'($urandom), ($urandom % 3) == 0 ? 10'($urandom) : 10'($urandom_range(0, 7)), 8'($urandom));
      cycle();
    end
    v = '0;
    cycle();
    // a reset with a read in flight drops the pending response
    set_req(0, 1, 0, 10'd3, 8'h00);
    cycle();
    v = '0;
    chk("inflight", 32'(rsp_valid), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rst_drop_v", 32'(rsp_valid), 32'd0);
    chk("rst_drop_d", rsp_rdata, 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
